l2_cache_arb_rr: RTL
====================

# l2_cache_arb_rr

Parametrised L2 pipeline arbitration stage feeding the tag lookup stage. It selects among NUM_CORES core request ports and the system memory interface (SMI) restart path each cycle, then registers the winner into the arb_* pipeline registers. SMI restarts have priority. Cores share the remaining slots round-robin. An optional starvation guard forces a core slot after a run of consecutive SMI wins.

## Interface
Parameters:
- NUM_CORES, 4, number of core request ports (2..8)
- CORE_IDX_W, 2, width of core index; must be >= clog2(NUM_CORES)
- ADDR_WIDTH, 26, line address width
- LINE_BITS, 512, cache line width; mask width is LINE_BITS/8
- STARVE_LIMIT, 8, consecutive SMI wins before a core slot is forced (guard only)

Ports (per-core fields are flattened, core i at slice i):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_pipeline  in  1  downstream stall; hold all arb_* registers
- core_req_valid  in  NUM_CORES  request pending per core
- core_req_ack  out  NUM_CORES  combinational; core i captured at this clock edge
- core_req_unit / core_req_strand / core_req_way  in  2*NUM_CORES  request fields
- core_req_op  in  3*NUM_CORES  operation
- core_req_address  in  ADDR_WIDTH*NUM_CORES  line address
- core_req_data  in  LINE_BITS*NUM_CORES  store data
- core_req_mask  in  (LINE_BITS/8)*NUM_CORES  byte mask
- smi_data_ready  in  1  restart request valid
- smi_accept  out  1  combinational; restart captured at this edge
- smi_l2req_core/unit/strand/op/way/address/data/mask  in  as core fields (core is CORE_IDX_W)  restart request
- smi_load_buffer_vec  in  LINE_BITS  fill data
- smi_fill_l2_way  in  2  fill way
- smi_duplicate_request  in  1  fill already present; no data to write
- arb_l2req_valid/core/unit/strand/op/way/address/data/mask  out  matching widths  registered request
- arb_has_sm_data  out  1  registered request carries fill data
- arb_sm_data  out  LINE_BITS  fill data
- arb_sm_fill_l2_way  out  2  fill way

## Operation
- Reset: all arb_* outputs are 0. rr_ptr = NUM_CORES-1, so core 0 has first priority. starve_cnt = 0.
- Stalled cycle: all arb_* registers, rr_ptr and starve_cnt hold. core_req_ack = 0 and smi_accept = 0.
- Unstalled cycle, decision in priority order:
  - SMI win (smi_data_ready, and the guard is not forcing a core slot):
    - smi_accept = 1; load the smi_* fields.
    - arb_l2req_valid = 1; arb_has_sm_data = !smi_duplicate_request.
    - arb_sm_data = smi_load_buffer_vec; arb_sm_fill_l2_way = smi_fill_l2_way.
  - Core win (any core valid): the winner is the first valid core searching upward from rr_ptr+1 mod NUM_CORES.
    - core_req_ack[winner] = 1; load the winner's fields.
    - arb_l2req_core = winner index; arb_l2req_valid = 1.
    - arb_has_sm_data = 0, arb_sm_data = 0, arb_sm_fill_l2_way = 0.
    - rr_ptr = winner.
  - Idle: arb_l2req_valid = 0, arb_has_sm_data = 0; other fields are don't-care.
- rr_ptr advances only on a core grant. SMI wins and idle cycles never move it.
- Requesters hold valid and fields stable until ack. A requester sees ack and the capture on the same edge, so no request is ever taken twice.
- At most one bit of core_req_ack | smi_accept is set in any cycle.

## Timing
- Latency: one cycle from the sampled inputs to arb_* outputs.
- Throughput: one request per unstalled cycle.
- core_req_ack and smi_accept are combinational from valids, stall_pipeline and internal state. They have no path from arb_* outputs.
- reset asserted mid-operation: the next edge clears all state. Acks are 0 while reset is high.

## Configuration
- L2_ARB_STARVE_GUARD_EN defined:
  - starve_cnt increments on each SMI win while any core_req_valid is set.
  - starve_cnt clears on any core grant, or when no core is valid. It saturates at STARVE_LIMIT.
  - While starve_cnt == STARVE_LIMIT and a core is valid, the unstalled cycle grants a core even if smi_data_ready is set. smi_accept = 0 and SMI must hold its request.
- Not defined: starve_cnt is absent, smi_accept = smi_data_ready & !stall_pipeline, and SMI always wins.

## Test plan
- Reset, then cores 0 and 2 valid continuously with no SMI:
  - grants alternate 0, 2, 0, 2;
  - arb_l2req_core follows one cycle after each ack;
  - arb_has_sm_data stays 0.
- All 4 cores valid continuously: acks rotate 0, 1, 2, 3, 0. Each core is granted exactly once per 4 cycles.
- smi_data_ready with smi_duplicate_request=0 while core 1 is valid:
  - smi_accept = 1 and core 1 gets no ack;
  - next cycle arb_has_sm_data = 1 and arb_sm_data = smi_load_buffer_vec;
  - the following cycle core 1 is granted.
- stall_pipeline high for 3 cycles with core 3 valid: acks stay 0 and arb_* are unchanged. Core 3 is acked on the first unstalled cycle.
- Guard enabled, STARVE_LIMIT=2, SMI and core 0 valid continuously: accept pattern is SMI, SMI, core 0, SMI, SMI, core 0. Guard disabled: SMI every cycle and core 0 never acked.
- reset asserted while requests are flowing: the next cycle has arb_l2req_valid = 0. The first grant after reset release goes to the lowest valid core.

Source files
------------

// File: rtl/l2_cache_arb_rr_if.sv
// -----------------------------------------------------------------------------
// l2_cache_arb_rr_if
// Bus bundle for the L2 arbitration stage: core request ports, the SMI restart
// path, the downstream stall and the registered arb_* pipeline outputs.
//
// Modports:
//   slave  - the arbiter (consumes requests, produces acks and arb_* outputs)
//   master - the environment driving requests and observing the arbiter
//
// Per-core fields are flattened, with core i at slice i.
// -----------------------------------------------------------------------------
interface l2_cache_arb_rr_if #(
    parameter int NUM_CORES  = 4,
    parameter int CORE_IDX_W = 2,
    parameter int ADDR_WIDTH = 26,
    parameter int LINE_BITS  = 512
);
    localparam int MASK_W = LINE_BITS / 8;

    logic                            stall_pipeline;

    logic [NUM_CORES-1:0]            core_req_valid;
    logic [NUM_CORES-1:0]            core_req_ack;
    logic [2*NUM_CORES-1:0]          core_req_unit;
    logic [2*NUM_CORES-1:0]          core_req_strand;
    logic [2*NUM_CORES-1:0]          core_req_way;
    logic [3*NUM_CORES-1:0]          core_req_op;
    logic [ADDR_WIDTH*NUM_CORES-1:0] core_req_address;
    logic [LINE_BITS*NUM_CORES-1:0]  core_req_data;
    logic [MASK_W*NUM_CORES-1:0]     core_req_mask;

    logic                            smi_data_ready;
    logic                            smi_accept;
    logic [CORE_IDX_W-1:0]           smi_l2req_core;
    logic [1:0]                      smi_l2req_unit;
    logic [1:0]                      smi_l2req_strand;
    logic [2:0]                      smi_l2req_op;
    logic [1:0]                      smi_l2req_way;
    logic [ADDR_WIDTH-1:0]           smi_l2req_address;
    logic [LINE_BITS-1:0]            smi_l2req_data;
    logic [MASK_W-1:0]               smi_l2req_mask;
    logic [LINE_BITS-1:0]            smi_load_buffer_vec;
    logic [1:0]                      smi_fill_l2_way;
    logic                            smi_duplicate_request;

    logic                            arb_l2req_valid;
    logic [CORE_IDX_W-1:0]           arb_l2req_core;
    logic [1:0]                      arb_l2req_unit;
    logic [1:0]                      arb_l2req_strand;
    logic [2:0]                      arb_l2req_op;
    logic [1:0]                      arb_l2req_way;
    logic [ADDR_WIDTH-1:0]           arb_l2req_address;
    logic [LINE_BITS-1:0]            arb_l2req_data;
    logic [MASK_W-1:0]               arb_l2req_mask;
    logic                            arb_has_sm_data;
    logic [LINE_BITS-1:0]            arb_sm_data;
    logic [1:0]                      arb_sm_fill_l2_way;

    modport slave (
        input  stall_pipeline,
        input  core_req_valid, core_req_unit, core_req_strand, core_req_way,
        input  core_req_op, core_req_address, core_req_data, core_req_mask,
        output core_req_ack,
        input  smi_data_ready, smi_l2req_core, smi_l2req_unit, smi_l2req_strand,
        input  smi_l2req_op, smi_l2req_way, smi_l2req_address, smi_l2req_data,
        input  smi_l2req_mask, smi_load_buffer_vec, smi_fill_l2_way,
        input  smi_duplicate_request,
        output smi_accept,
        output arb_l2req_valid, arb_l2req_core, arb_l2req_unit, arb_l2req_strand,
        output arb_l2req_op, arb_l2req_way, arb_l2req_address, arb_l2req_data,
        output arb_l2req_mask, arb_has_sm_data, arb_sm_data, arb_sm_fill_l2_way
    );

    modport master (
        output stall_pipeline,
        output core_req_valid, core_req_unit, core_req_strand, core_req_way,
        output core_req_op, core_req_address, core_req_data, core_req_mask,
        input  core_req_ack,
        output smi_data_ready, smi_l2req_core, smi_l2req_unit, smi_l2req_strand,
        output smi_l2req_op, smi_l2req_way, smi_l2req_address, smi_l2req_data,
        output smi_l2req_mask, smi_load_buffer_vec, smi_fill_l2_way,
        output smi_duplicate_request,
        input  smi_accept,
        input  arb_l2req_valid, arb_l2req_core, arb_l2req_unit, arb_l2req_strand,
        input  arb_l2req_op, arb_l2req_way, arb_l2req_address, arb_l2req_data,
        input  arb_l2req_mask, arb_has_sm_data, arb_sm_data, arb_sm_fill_l2_way
    );
endinterface

// File: rtl/l2_cache_arb_rr.sv
// -----------------------------------------------------------------------------
// l2_cache_arb_rr
// L2 pipeline arbitration stage feeding tag lookup. Each unstalled cycle it
// picks one of: an SMI restart (highest priority) or a core request chosen
// round-robin, and registers it into the arb_* outputs (one cycle latency).
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   bus    - l2_cache_arb_rr_if.slave: core requests/acks, SMI restart and
//            accept, stall_pipeline, registered arb_* outputs
//
// Optional feature (macro L2_ARB_STARVE_GUARD_EN): after STARVE_LIMIT
// consecutive SMI wins with a core waiting, the next unstalled cycle is given
// to a core while SMI holds its request.
// -----------------------------------------------------------------------------
module l2_cache_arb_rr #(
    parameter int NUM_CORES    = 4,
    parameter int CORE_IDX_W   = 2,
    parameter int ADDR_WIDTH   = 26,
    parameter int LINE_BITS    = 512,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    l2_cache_arb_rr_if.slave      bus
);
    localparam int MASK_W = LINE_BITS / 8;

    logic [CORE_IDX_W-1:0] rr_ptr;
    logic [CORE_IDX_W-1:0] winner;
    logic [CORE_IDX_W-1:0] cand;
    logic                  core_found;
    logic                  core_any;
    logic                  force_core;
    logic                  smi_win;
    logic                  core_win;

    logic [1:0]            sel_unit;
    logic [1:0]            sel_strand;
    logic [1:0]            sel_way;
    logic [2:0]            sel_op;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [LINE_BITS-1:0]  sel_data;
    logic [MASK_W-1:0]     sel_mask;

    assign core_any = |bus.core_req_valid;

    // Round-robin search starting just above the last granted core, then a
    // constant-index mux to pull out the winner's request fields.
    always_comb begin
        core_found  = 1'b0;
        winner      = '0;
        cand        = '0;
        sel_unit    = '0;
        sel_strand  = '0;
        sel_way     = '0;
        sel_op      = '0;
        sel_address = '0;
        sel_data    = '0;
        sel_mask    = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = CORE_IDX_W'((int'(rr_ptr) + i) % NUM_CORES);
            if (!core_found && bus.core_req_valid[cand]) begin
                core_found = 1'b1;
                winner     = cand;
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (winner == CORE_IDX_W'(i)) begin
                sel_unit    = bus.core_req_unit[i*2 +: 2];
                sel_strand  = bus.core_req_strand[i*2 +: 2];
                sel_way     = bus.core_req_way[i*2 +: 2];
                sel_op      = bus.core_req_op[i*3 +: 3];
                sel_address = bus.core_req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data    = bus.core_req_data[i*LINE_BITS +: LINE_BITS];
                sel_mask    = bus.core_req_mask[i*MASK_W +: MASK_W];
            end
        end
    end

`ifdef L2_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;

    assign force_core = (starve_cnt == SC_W'(STARVE_LIMIT)) && core_any;

    // Counts consecutive SMI wins that left a core waiting; any core grant or
    // a cycle with no core pending restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!bus.stall_pipeline) begin
            if (core_win || !core_any) begin
                starve_cnt <= '0;
            end else if (smi_win && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign force_core = 1'b0;
`endif

    // Acks depend only on valids, stall, reset and internal state so the
    // requesters see them in the same cycle the capture happens.
    assign smi_win  = bus.smi_data_ready && !bus.stall_pipeline && !reset && !force_core;
    assign core_win = core_any && !bus.stall_pipeline && !reset && !smi_win;

    assign bus.smi_accept   = smi_win;
    assign bus.core_req_ack = core_win ? (NUM_CORES'(1) << winner) : '0;

    // Pipeline register: SMI restart, core winner or an idle bubble. Idle
    // cycles only drop the valid flags; the payload fields are don't-care.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr                 <= CORE_IDX_W'(NUM_CORES - 1);
            bus.arb_l2req_valid    <= 1'b0;
            bus.arb_l2req_core     <= '0;
            bus.arb_l2req_unit     <= '0;
            bus.arb_l2req_strand   <= '0;
            bus.arb_l2req_op       <= '0;
            bus.arb_l2req_way      <= '0;
            bus.arb_l2req_address  <= '0;
            bus.arb_l2req_data     <= '0;
            bus.arb_l2req_mask     <= '0;
            bus.arb_has_sm_data    <= 1'b0;
            bus.arb_sm_data        <= '0;
            bus.arb_sm_fill_l2_way <= '0;
        end else if (!bus.stall_pipeline) begin
            if (smi_win) begin
                bus.arb_l2req_valid    <= 1'b1;
                bus.arb_l2req_core     <= bus.smi_l2req_core;
                bus.arb_l2req_unit     <= bus.smi_l2req_unit;
                bus.arb_l2req_strand   <= bus.smi_l2req_strand;
                bus.arb_l2req_op       <= bus.smi_l2req_op;
                bus.arb_l2req_way      <= bus.smi_l2req_way;
                bus.arb_l2req_address  <= bus.smi_l2req_address;
                bus.arb_l2req_data     <= bus.smi_l2req_data;
                bus.arb_l2req_mask     <= bus.smi_l2req_mask;
                bus.arb_has_sm_data    <= !bus.smi_duplicate_request;
                bus.arb_sm_data        <= bus.smi_load_buffer_vec;
                bus.arb_sm_fill_l2_way <= bus.smi_fill_l2_way;
            end else if (core_win) begin
                rr_ptr                 <= winner;
                bus.arb_l2req_valid    <= 1'b1;
                bus.arb_l2req_core     <= winner;
                bus.arb_l2req_unit     <= sel_unit;
                bus.arb_l2req_strand   <= sel_strand;
                bus.arb_l2req_op       <= sel_op;
                bus.arb_l2req_way      <= sel_way;
                bus.arb_l2req_address  <= sel_address;
                bus.arb_l2req_data     <= sel_data;
                bus.arb_l2req_mask     <= sel_mask;
                bus.arb_has_sm_data    <= 1'b0;
                bus.arb_sm_data        <= '0;
                bus.arb_sm_fill_l2_way <= '0;
            end else begin
                bus.arb_l2req_valid    <= 1'b0;
                bus.arb_has_sm_data    <= 1'b0;
            end
        end
    end
endmodule
